// File: rtl/redpi_dac_fmt.sv
// DAC sample formatter/sequencer: 2-frame input FIFO, per-channel round/saturate/format,
// one channel word per clock, with reset/mute start-up sequencing and underflow fill.

module redpi_dac_cvt #(
   parameter int IN_W   = 16,
   parameter int DAC_W  = 14,
   parameter int FORMAT = 1,
   parameter int ROUND  = 1
) (
   input  logic [IN_W-1:0]  x,
   output logic [DAC_W-1:0] code
);
   localparam int SH = IN_W - DAC_W;
   localparam logic [IN_W:0] HALF = (ROUND != 0 && SH > 0) ?
                                    ((IN_W+1)'(1) << (SH > 0 ? SH - 1 : 0)) : '0;

   logic [IN_W:0]    r;
   logic [DAC_W:0]   t;
   logic [DAC_W-1:0] tc;

   // One guard bit above the sample; after the shift only a positive carry into it can occur.
   assign r  = {x[IN_W-1], x} + HALF;
   assign t  = (DAC_W+1)'(r >> SH);
   assign tc = (t[DAC_W] != t[DAC_W-1]) ? {1'b0, {(DAC_W-1){1'b1}}} : t[DAC_W-1:0];
   assign code = (FORMAT != 0) ? {~tc[DAC_W-1], tc[DAC_W-2:0]} : tc;
endmodule

module redpi_dac_fmt #(
   parameter int NCH         = 2,
   parameter int IN_W        = 16,
   parameter int DAC_W       = 14,
   parameter int FORMAT      = 1,
   parameter int ROUND       = 1,
   parameter int HOLD_LAST   = 0,
   parameter int RST_CYCLES  = 16,
   parameter int MUTE_CYCLES = 32,
   localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  dac_clk_1x,
   input  logic                  dac_rst,
   input  logic                  en,
   input  logic [NCH*IN_W-1:0]   s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DAC_W-1:0]      dac_dat_o,
   output logic [SEL_W-1:0]      dac_sel_o,
   output logic                  dac_frame_o,
   output logic                  dac_rst_o,
   output logic                  running_o,
   output logic                  underflow_o,
   output logic [15:0]           underflow_cnt_o
);
   localparam int MAXC  = (RST_CYCLES > MUTE_CYCLES) ? RST_CYCLES : MUTE_CYCLES;
   localparam int CNT_W = $clog2(MAXC + 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] MUTE_LAST = CNT_W'(MUTE_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST      = SEL_W'(NCH - 1);
   localparam logic [DAC_W-1:0] MID       = (FORMAT != 0) ? {1'b1, {(DAC_W-1){1'b0}}} : '0;

   typedef enum logic [1:0] {S_RST, S_MUTE, S_RUN} state_t;

   state_t                       state, state_n;
   logic [CNT_W-1:0]             cnt, cnt_n;
   logic [SEL_W-1:0]             slot, slot_n;
   logic [NCH*IN_W-1:0]          mem [2];
   logic                         wr_ptr, rd_ptr;
   logic [1:0]                   count, count_n;
   logic                         push, pop, frame_start, uflow;
   logic [NCH-1:0][DAC_W-1:0]    head_code, frame_q, frame_d;
   logic [DAC_W-1:0]             word;

   assign push        = s_tvalid && s_tready && (state != S_RST);
   assign frame_start = (state == S_RUN) && (slot == '0);
   assign pop         = frame_start && (count != 2'd0);
   assign uflow       = frame_start && (count == 2'd0);

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      redpi_dac_cvt #(
         .IN_W(IN_W), .DAC_W(DAC_W), .FORMAT(FORMAT), .ROUND(ROUND)
      ) u_cvt (
         .x    (mem[rd_ptr][k*IN_W +: IN_W]),
         .code (head_code[k])
      );
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_RST:
            if (cnt == RST_LAST) begin
               state_n = S_MUTE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         S_MUTE:
            if (cnt == MUTE_LAST) begin
               if (en) begin
                  state_n = S_RUN;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         S_RUN:
            // Stop requests are only honoured once the frame's last word is out.
            if (slot == LAST && !en) begin
               state_n = S_MUTE;
               cnt_n   = '0;
            end
         default: state_n = S_RST;
      endcase
   end

   always_comb begin
      slot_n = slot + SEL_W'(1);
      if (state == S_RST || (state == S_MUTE && state_n == S_RUN) || slot == LAST)
         slot_n = '0;

      count_n = count;
      unique case ({push, pop})
         2'b10:   count_n = count + 2'd1;
         2'b01:   count_n = count - 2'd1;
         default: count_n = count;
      endcase

      frame_d = frame_q;
      if (pop)
         frame_d = head_code;
      else if (HOLD_LAST == 0)
         frame_d = {NCH{MID}};

      // Channel 0 bypasses the frame register so the word leaves on the pop cycle.
      word = (slot == '0) ? frame_d[0] : frame_q[slot];
   end

   always_ff @(posedge dac_clk_1x) begin
      if (push) mem[wr_ptr] <= s_tdata;
   end

   always_ff @(posedge dac_clk_1x) begin
      if (dac_rst) begin
         state           <= S_RST;
         cnt             <= '0;
         slot            <= '0;
         wr_ptr          <= 1'b0;
         rd_ptr          <= 1'b0;
         count           <= 2'd0;
         frame_q         <= {NCH{MID}};
         s_tready        <= 1'b0;
         dac_dat_o       <= MID;
         dac_sel_o       <= '0;
         dac_frame_o     <= 1'b0;
         dac_rst_o       <= 1'b1;
         running_o       <= 1'b0;
         underflow_o     <= 1'b0;
         underflow_cnt_o <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         slot      <= slot_n;
         count     <= count_n;
         s_tready  <= (state_n != S_RST) && (count_n != 2'd2);
         dac_rst_o <= (state_n == S_RST);
         running_o <= (state_n == S_RUN);
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (frame_start) frame_q <= frame_d;

         underflow_o <= uflow;
         if (uflow && underflow_cnt_o != 16'hFFFF)
            underflow_cnt_o <= underflow_cnt_o + 16'd1;

         if (state == S_RUN) begin
            dac_dat_o   <= word;
            dac_sel_o   <= slot;
            dac_frame_o <= (slot == '0);
         end else begin
            dac_dat_o   <= MID;
            dac_sel_o   <= (state == S_MUTE) ? slot : '0;
            dac_frame_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_redpi_dac_fmt.sv
// Directed bench for redpi_dac_fmt: start-up sequencing, conversion, underflow, stop/restart,
// mid-run reset; a monitor checks every emitted frame against a scoreboard queue.

module tb_redpi_dac_fmt;
   logic        clk = 1'b0;
   logic        dac_rst, en, s_tvalid;
   logic [31:0] s_tdata;
   logic        s_tready, dac_frame_o, dac_rst_o, running_o, underflow_o;
   logic [13:0] dac_dat_o;
   logic [0:0]  dac_sel_o;
   logic [15:0] underflow_cnt_o;

   logic        h_rdy, h_frame, h_rst, h_run, h_uf;
   logic [13:0] h_dat;
   logic [0:0]  h_sel;
   logic [15:0] h_cnt;

   int          n_cmp = 0, n_err = 0;
   logic        mon_en = 1'b1;
   logic [27:0] exp_q [$];

   always #5 clk = ~clk;

   redpi_dac_fmt #(
      .NCH(2), .IN_W(16), .DAC_W(14), .FORMAT(1), .ROUND(1), .HOLD_LAST(0),
      .RST_CYCLES(16), .MUTE_CYCLES(32)
   ) dut (
      .dac_clk_1x(clk), .dac_rst(dac_rst), .en(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(s_tready), .dac_dat_o(dac_dat_o), .dac_sel_o(dac_sel_o),
      .dac_frame_o(dac_frame_o), .dac_rst_o(dac_rst_o), .running_o(running_o),
      .underflow_o(underflow_o), .underflow_cnt_o(underflow_cnt_o)
   );

   // Identical stimulus, repeat-last underflow fill.
   redpi_dac_fmt #(
      .NCH(2), .IN_W(16), .DAC_W(14), .FORMAT(1), .ROUND(1), .HOLD_LAST(1),
      .RST_CYCLES(16), .MUTE_CYCLES(32)
   ) dut_hold (
      .dac_clk_1x(clk), .dac_rst(dac_rst), .en(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(h_rdy), .dac_dat_o(h_dat), .dac_sel_o(h_sel),
      .dac_frame_o(h_frame), .dac_rst_o(h_rst), .running_o(h_run),
      .underflow_o(h_uf), .underflow_cnt_o(h_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Round half up, >>2, clip positive overflow, offset binary.
   function automatic logic [13:0] conv(input logic [15:0] x);
      int v;
      v = int'($signed(x)) + 2;
      v = v >>> 2;
      if (v > 8191) v = 8191;
      return 14'(v) ^ 14'h2000;
   endfunction

   // Call at a negedge; a frame driven while s_tready is high is accepted on the next edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b);
      int t = 0;
      while (!s_tready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("send_ready", 32'(s_tready), 32'd1);
      if (s_tready) begin
         s_tdata  = {b, a};
         s_tvalid = 1'b1;
         exp_q.push_back({conv(b), conv(a)});
         @(negedge clk);
         s_tvalid = 1'b0;
      end
   endtask

   initial begin : monitor
      logic [13:0] cur [2];
      logic [27:0] e;
      int idx;
      idx = 2;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            idx = 2;
         end else if (dac_frame_o) begin
            if (underflow_o) begin
               cur[0] = 14'h2000;
               cur[1] = 14'h2000;
            end else begin
               chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
               e = (exp_q.size() != 0) ? exp_q.pop_front() : 28'h0;
               cur[0] = e[13:0];
               cur[1] = e[27:14];
            end
            chk("mon_word0", 32'(dac_dat_o), 32'(cur[0]));
            chk("mon_sel0", 32'(dac_sel_o), 32'd0);
            idx = 1;
         end else if (idx < 2) begin
            chk("mon_word1", 32'(dac_dat_o), 32'(cur[idx]));
            chk("mon_sel1", 32'(dac_sel_o), 32'd1);
            idx++;
         end
      end
   end

   initial begin
      int n;
      logic full_seen;
      logic [15:0] a, b;
      dac_rst = 1'b1; en = 1'b1; s_tvalid = 1'b0; s_tdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_dat", 32'(dac_dat_o), 32'h2000);
      chk("rst_sel", 32'(dac_sel_o), 32'd0);
      chk("rst_frame", 32'(dac_frame_o), 32'd0);
      chk("rst_rsto", 32'(dac_rst_o), 32'd1);
      chk("rst_run", 32'(running_o), 32'd0);
      chk("rst_uf", 32'(underflow_o), 32'd0);
      chk("rst_ufcnt", 32'(underflow_cnt_o), 32'd0);
      chk("rst_rdy", 32'(s_tready), 32'd0);

      // Start-up: reset pulse length, then mute length, with two frames queued during mute.
      dac_rst = 1'b0;
      n = 0;
      while (dac_rst_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("rst_cycles", 32'(n), 32'd16);
      chk("mute_mid_first", 32'(dac_dat_o), 32'h2000);
      send(16'h7FFF, 16'h8000);
      send(16'h0002, 16'hFFFD);
      n = 2;
      while (!running_o && n < 100) begin
         chk("mute_mid", 32'(dac_dat_o), 32'h2000);
         n++;
         @(negedge clk);
      end
      chk("mute_cycles", 32'(n), 32'd32);

      // First RUN cycle pops frame 1; words follow one per cycle.
      @(negedge clk);
      chk("f1_w0", 32'(dac_dat_o), 32'h3FFF);
      chk("f1_frame", 32'(dac_frame_o), 32'd1);
      @(negedge clk);
      chk("f1_w1", 32'(dac_dat_o), 32'h0000);
      chk("f1_sel", 32'(dac_sel_o), 32'd1);
      chk("f1_frame1", 32'(dac_frame_o), 32'd0);
      @(negedge clk);
      chk("f2_w0", 32'(dac_dat_o), 32'h2001);
      @(negedge clk);
      chk("f2_w1", 32'(dac_dat_o), 32'h1FFF);
      chk("f2_uf", 32'(underflow_o), 32'd0);

      // FIFO now empty: two underflow frames.
      @(negedge clk);
      chk("uf1_pulse", 32'(underflow_o), 32'd1);
      chk("uf1_dat", 32'(dac_dat_o), 32'h2000);
      chk("uf1_cnt", 32'(underflow_cnt_o), 32'd1);
      chk("uf1_hold0", 32'(h_dat), 32'h2001);
      @(negedge clk);
      chk("uf1_pulse_end", 32'(underflow_o), 32'd0);
      chk("uf1_dat1", 32'(dac_dat_o), 32'h2000);
      chk("uf1_hold1", 32'(h_dat), 32'h1FFF);
      @(negedge clk);
      chk("uf2_pulse", 32'(underflow_o), 32'd1);
      chk("uf2_cnt", 32'(underflow_cnt_o), 32'd2);
      chk("uf2_hold0", 32'(h_dat), 32'h2001);

      // Recovery plus rounding/saturation boundaries.
      send(16'h7FFD, 16'h8001);
      send(16'h7FFE, 16'h0001);
      send(16'h1234, 16'hEDCB);
      send(16'hFFFE, 16'h0006);
      send(16'h4000, 16'hC000);

      // Drop en at a slot-0 cycle: current frame completes, then mute.
      n = 0;
      while (!(running_o && dac_sel_o == 1'b1) && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("stop_point_found", 32'(running_o && dac_sel_o == 1'b1), 32'd1);
      en = 1'b0;
      @(negedge clk);
      chk("stop_frame_start", 32'(dac_frame_o), 32'd1);
      @(negedge clk);
      chk("stop_run_low", 32'(running_o), 32'd0);
      chk("stop_last_sel", 32'(dac_sel_o), 32'd1);
      @(negedge clk);
      chk("stop_mid", 32'(dac_dat_o), 32'h2000);
      en = 1'b1;
      n = 1;
      full_seen = 1'b0;
      while (!running_o && n < 100) begin
         n++;
         if (!s_tready) full_seen = 1'b1;
         if (s_tready) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s_tdata  = {b, a};
            s_tvalid = 1'b1;
            exp_q.push_back({conv(b), conv(a)});
         end else begin
            s_tvalid = 1'b0;
         end
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      chk("remute_cycles", 32'(n), 32'd32);
      chk("mute_fifo_full", 32'(full_seen), 32'd1);

      // Keep feeding in RUN, then reset with the FIFO full.
      for (int i = 0; i < 30; i++) begin
         if (i >= 8 && !s_tready) break;
         if (s_tready) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s_tdata  = {b, a};
            s_tvalid = 1'b1;
            exp_q.push_back({conv(b), conv(a)});
         end else begin
            s_tvalid = 1'b0;
         end
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      chk("pre_rst_full", 32'(s_tready), 32'd0);
      chk("pre_rst_run", 32'(running_o), 32'd1);
      chk("pre_rst_ufcnt", 32'(underflow_cnt_o), 32'd2);
      mon_en  = 1'b0;
      dac_rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mrst_dat", 32'(dac_dat_o), 32'h2000);
      chk("mrst_sel", 32'(dac_sel_o), 32'd0);
      chk("mrst_frame", 32'(dac_frame_o), 32'd0);
      chk("mrst_rsto", 32'(dac_rst_o), 32'd1);
      chk("mrst_run", 32'(running_o), 32'd0);
      chk("mrst_uf", 32'(underflow_o), 32'd0);
      chk("mrst_ufcnt", 32'(underflow_cnt_o), 32'd0);
      chk("mrst_rdy", 32'(s_tready), 32'd0);
      dac_rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_rsto", 32'(dac_rst_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
